// File: rtl/cdb_writeback_arbiter.sv
// Common data bus writeback arbiter: buffers adder and mult/div results in per-unit FIFOs and
// broadcasts one result per cycle, round-robin between the two units when both have work.
module cdb_writeback_arbiter #(
    parameter int  DATA_W     = 16,
    parameter int  TAG_W      = 4,
    parameter int  FIFO_DEPTH = 2,
    localparam int PW         = $clog2(FIFO_DEPTH),
    localparam int CW         = PW + 1
) (
    input  logic              clock1,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              add_valid,
    output logic              add_ready,
    input  logic [TAG_W-1:0]  add_tag,
    input  logic [DATA_W-1:0] add_data,
    input  logic              mul_valid,
    output logic              mul_ready,
    input  logic [TAG_W-1:0]  mul_tag,
    input  logic [DATA_W-1:0] mul_data,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_src,
    output logic [CW-1:0]     add_cnt,
    output logic [CW-1:0]     mul_cnt
);

    // Unit index 0 = adder, 1 = mult/div; matches the encoding of cdb_src.
    logic [1:0]                          in_valid;
    logic [1:0][TAG_W-1:0]               in_tag;
    logic [1:0][DATA_W-1:0]              in_data;
    logic [1:0][CW-1:0]                  cnt;
    logic [1:0][TAG_W+DATA_W-1:0]        head;
    logic [1:0]                          unit_ready;
    logic [1:0]                          nonempty;
    logic [1:0]                          push;
    logic [1:0]                          pop;
    logic                                sel;
    logic                                any_req;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;
    logic              cdb_src_q,   cdb_src_d;
    logic              last_grant_q, last_grant_d;

    assign in_valid = {mul_valid, add_valid};
    assign in_tag   = {mul_tag, add_tag};
    assign in_data  = {mul_data, add_data};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [TAG_W+DATA_W-1:0] mem [FIFO_DEPTH];
            logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
            logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
            logic [CW-1:0]           cnt_q,    cnt_d;

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                cnt_d    = cnt_q;
                if (flush) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                end else begin
                    if (push[gi]) wr_ptr_d = wr_ptr_q + PW'(1);
                    if (pop[gi])  rd_ptr_d = rd_ptr_q + PW'(1);
                    case ({push[gi], pop[gi]})
                        2'b10:   cnt_d = cnt_q + CW'(1);
                        2'b01:   cnt_d = cnt_q - CW'(1);
                        default: cnt_d = cnt_q;
                    endcase
                end
            end

            always_ff @(posedge clock1 or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_d;
                end
            end

            // Payload storage needs no reset: occupancy alone decides what is valid.
            always_ff @(posedge clock1) begin
                if (push[gi]) mem[wr_ptr_q] <= {in_tag[gi], in_data[gi]};
            end

            assign cnt[gi]        = cnt_q;
            assign head[gi]       = mem[rd_ptr_q];
            assign unit_ready[gi] = (cnt_q != CW'(FIFO_DEPTH));
            assign nonempty[gi]   = (cnt_q != '0);
        end
    endgenerate

    always_comb begin
        any_req      = |nonempty;
        sel          = (nonempty == 2'b11) ? ~last_grant_q : nonempty[1];
        push         = in_valid & unit_ready & {2{~flush}};
        pop          = 2'b00;
        cdb_valid_d  = 1'b0;
        cdb_tag_d    = cdb_tag_q;
        cdb_data_d   = cdb_data_q;
        cdb_src_d    = cdb_src_q;
        last_grant_d = last_grant_q;
        if (any_req && !flush) begin
            pop[sel]                 = 1'b1;
            cdb_valid_d              = 1'b1;
            {cdb_tag_d, cdb_data_d}  = head[sel];
            cdb_src_d                = sel;
            last_grant_d             = sel;
        end
    end

    // last_grant resets to the mult/div side so the adder wins the first tie.
    always_ff @(posedge clock1 or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_data_q   <= '0;
            cdb_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_data_q   <= cdb_data_d;
            cdb_src_q    <= cdb_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign add_ready = unit_ready[0];
    assign mul_ready = unit_ready[1];
    assign add_cnt   = cnt[0];
    assign mul_cnt   = cnt[1];
    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Directed bench for cdb_writeback_arbiter: vector table for single-cycle behaviour plus
// hand-written sequences for dual streams and asynchronous reset mid-stream.
module tb_cdb_writeback_arbiter;

    logic        clock1 = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        add_valid, mul_valid;
    logic        add_ready, mul_ready;
    logic [3:0]  add_tag, mul_tag;
    logic [15:0] add_data, mul_data;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        cdb_src;
    logic [1:0]  add_cnt, mul_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clock1 = ~clock1;

    cdb_writeback_arbiter #(.DATA_W(16), .TAG_W(4), .FIFO_DEPTH(2)) dut (
        .clock1    (clock1),
        .rst_n     (rst_n),
        .flush     (flush),
        .add_valid (add_valid),
        .add_ready (add_ready),
        .add_tag   (add_tag),
        .add_data  (add_data),
        .mul_valid (mul_valid),
        .mul_ready (mul_ready),
        .mul_tag   (mul_tag),
        .mul_data  (mul_data),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src),
        .add_cnt   (add_cnt),
        .mul_cnt   (mul_cnt)
    );

    typedef struct {
        logic        av;
        logic [3:0]  at;
        logic [15:0] ad;
        logic        mv;
        logic [3:0]  mt;
        logic [15:0] md;
        logic        fl;
        logic        ev;
        logic [3:0]  et;
        logic [15:0] ed;
        logic        es;
        logic [1:0]  eac;
        logic [1:0]  emc;
        logic        ear;
        logic        emr;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs [NV];

    function automatic vec_t mk(input int av, input int at, input int ad,
                                input int mv, input int mt, input int md, input int fl,
                                input int ev, input int et, input int ed, input int es,
                                input int eac, input int emc, input int ear, input int emr);
        vec_t v;
        v.av = 1'(av);   v.at = 4'(at);   v.ad = 16'(ad);
        v.mv = 1'(mv);   v.mt = 4'(mt);   v.md = 16'(md);
        v.fl = 1'(fl);
        v.ev = 1'(ev);   v.et = 4'(et);   v.ed = 16'(ed);   v.es = 1'(es);
        v.eac = 2'(eac); v.emc = 2'(emc); v.ear = 1'(ear);  v.emr = 1'(emr);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [3:0] at, input logic [15:0] ad,
                         input logic mv, input logic [3:0] mt, input logic [15:0] md,
                         input logic fl);
        add_valid = av; add_tag = at; add_data = ad;
        mul_valid = mv; mul_tag = mt; mul_data = md;
        flush = fl;
    endtask

    task automatic step();
        @(posedge clock1);
        #1;
    endtask

    initial begin
        int ai, mi, ea, em, nev;
        logic acc_a, acc_m;

        // Single-cycle behaviour: tie after reset, single add, full+pop, flush, backpressure.
        vecs[0]  = mk(1,1,5,       1,2,42,     0, 0,0,0,0,        1,1, 1,1);
        vecs[1]  = mk(0,0,0,       0,0,0,      0, 1,1,5,0,        0,1, 1,1);
        vecs[2]  = mk(0,0,0,       0,0,0,      0, 1,2,42,1,       0,0, 1,1);
        vecs[3]  = mk(0,0,0,       0,0,0,      0, 0,2,42,1,       0,0, 1,1);
        vecs[4]  = mk(1,3,9,       0,0,0,      0, 0,2,42,1,       1,0, 1,1);
        vecs[5]  = mk(0,0,0,       0,0,0,      0, 1,3,9,0,        0,0, 1,1);
        vecs[6]  = mk(0,0,0,       0,0,0,      0, 0,3,9,0,        0,0, 1,1);
        vecs[7]  = mk(1,4,'h10,    1,6,'h20,   0, 0,3,9,0,        1,1, 1,1);
        vecs[8]  = mk(1,5,'h11,    0,0,0,      0, 1,6,'h20,1,     2,0, 0,1);
        vecs[9]  = mk(1,7,'h12,    1,8,'h21,   0, 1,4,'h10,0,     1,1, 1,1);
        vecs[10] = mk(1,7,'h12,    0,0,0,      0, 1,8,'h21,1,     2,0, 0,1);
        vecs[11] = mk(0,0,0,       0,0,0,      0, 1,5,'h11,0,     1,0, 1,1);
        vecs[12] = mk(0,0,0,       0,0,0,      0, 1,7,'h12,0,     0,0, 1,1);
        vecs[13] = mk(0,0,0,       0,0,0,      0, 0,7,'h12,0,     0,0, 1,1);
        vecs[14] = mk(1,9,'h30,    1,10,'h40,  0, 0,7,'h12,0,     1,1, 1,1);
        vecs[15] = mk(1,11,'h31,   1,12,'h41,  0, 1,10,'h40,1,    2,1, 0,1);
        vecs[16] = mk(1,13,'h50,   1,14,'h51,  1, 0,10,'h40,1,    0,0, 1,1);
        vecs[17] = mk(0,0,0,       0,0,0,      0, 0,10,'h40,1,    0,0, 1,1);
        vecs[18] = mk(1,1,'h61,    1,2,'h62,   0, 0,10,'h40,1,    1,1, 1,1);
        vecs[19] = mk(0,0,0,       0,0,0,      0, 1,1,'h61,0,     0,1, 1,1);
        vecs[20] = mk(0,0,0,       0,0,0,      0, 1,2,'h62,1,     0,0, 1,1);
        vecs[21] = mk(0,0,0,       0,0,0,      0, 0,2,'h62,1,     0,0, 1,1);
        vecs[22] = mk(1,1,101,     1,8,80,     0, 0,2,'h62,1,     1,1, 1,1);
        vecs[23] = mk(1,2,102,     1,9,81,     0, 1,1,101,0,      1,2, 1,0);
        vecs[24] = mk(1,3,103,     1,10,82,    0, 1,8,80,1,       2,1, 0,1);
        vecs[25] = mk(1,4,104,     1,10,82,    0, 1,2,102,0,      1,2, 1,0);
        vecs[26] = mk(1,4,104,     0,0,0,      0, 1,9,81,1,       2,1, 0,1);
        vecs[27] = mk(0,0,0,       0,0,0,      0, 1,3,103,0,      1,1, 1,1);
        vecs[28] = mk(0,0,0,       0,0,0,      0, 1,10,82,1,      1,0, 1,1);
        vecs[29] = mk(0,0,0,       0,0,0,      0, 1,4,104,0,      0,0, 1,1);
        vecs[30] = mk(0,0,0,       0,0,0,      0, 0,4,104,0,      0,0, 1,1);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock1);
        #1;
        chk("reset cdb_valid", 32'(cdb_valid), 0);
        chk("reset cdb_tag",   32'(cdb_tag),   0);
        chk("reset cdb_data",  32'(cdb_data),  0);
        chk("reset cdb_src",   32'(cdb_src),   0);
        chk("reset add_cnt",   32'(add_cnt),   0);
        chk("reset mul_cnt",   32'(mul_cnt),   0);
        @(negedge clock1);
        rst_n = 1'b1;
        step();
        chk("post-reset add_ready", 32'(add_ready), 1);
        chk("post-reset mul_ready", 32'(mul_ready), 1);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].av, vecs[i].at, vecs[i].ad, vecs[i].mv, vecs[i].mt, vecs[i].md, vecs[i].fl);
            step();
            chk($sformatf("v%0d cdb_valid", i), 32'(cdb_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d cdb_tag", i),   32'(cdb_tag),   32'(vecs[i].et));
            chk($sformatf("v%0d cdb_data", i),  32'(cdb_data),  32'(vecs[i].ed));
            chk($sformatf("v%0d cdb_src", i),   32'(cdb_src),   32'(vecs[i].es));
            chk($sformatf("v%0d add_cnt", i),   32'(add_cnt),   32'(vecs[i].eac));
            chk($sformatf("v%0d mul_cnt", i),   32'(mul_cnt),   32'(vecs[i].emc));
            chk($sformatf("v%0d add_ready", i), 32'(add_ready), 32'(vecs[i].ear));
            chk($sformatf("v%0d mul_ready", i), 32'(mul_ready), 32'(vecs[i].emr));
            $display("vec %0d: cdb_valid=%0b tag=%0d data=%0h src=%0b add_cnt=%0d mul_cnt=%0d",
                     i, cdb_valid, cdb_tag, cdb_data, cdb_src, add_cnt, mul_cnt);
        end

        // Dual streams of 6: last grant went to the adder, so mult/div leads and grants alternate.
        ai = 0; mi = 0; ea = 0; em = 0; nev = 0;
        for (int cyc = 0; cyc < 80 && nev < 12; cyc++) begin
            add_valid = (ai < 6); add_tag = 4'(ai);     add_data = 16'h0100 + 16'(ai);
            mul_valid = (mi < 6); mul_tag = 4'(8 + mi); mul_data = 16'hA000 + 16'(mi);
            flush = 1'b0;
            acc_a = add_valid && add_ready;
            acc_m = mul_valid && mul_ready;
            step();
            if (acc_a) ai++;
            if (acc_m) mi++;
            if (cdb_valid) begin
                chk($sformatf("stream ev%0d src", nev), 32'(cdb_src), (nev % 2 == 0) ? 1 : 0);
                if (cdb_src == 1'b0) begin
                    chk($sformatf("stream add%0d tag", ea),  32'(cdb_tag),  32'(ea));
                    chk($sformatf("stream add%0d data", ea), 32'(cdb_data), 32'h0100 + 32'(ea));
                    ea++;
                end else begin
                    chk($sformatf("stream mul%0d tag", em),  32'(cdb_tag),  32'(8 + em));
                    chk($sformatf("stream mul%0d data", em), 32'(cdb_data), 32'hA000 + 32'(em));
                    em++;
                end
                $display("stream ev %0d: src=%0b tag=%0d data=%0h", nev, cdb_src, cdb_tag, cdb_data);
                nev++;
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("stream event count", 32'(nev), 12);
        step();
        chk("stream drained cdb_valid", 32'(cdb_valid), 0);

        // Asynchronous reset while results are buffered and a broadcast is live.
        drive(1, 5, 7, 0, 0, 0, 0);
        step();
        drive(1, 7, 9, 1, 6, 8, 0);
        step();
        chk("pre-reset cdb_valid", 32'(cdb_valid), 1);
        chk("pre-reset cdb_tag",   32'(cdb_tag),   5);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset cdb_valid", 32'(cdb_valid), 0);
        chk("async reset cdb_tag",   32'(cdb_tag),   0);
        chk("async reset cdb_data",  32'(cdb_data),  0);
        chk("async reset add_cnt",   32'(add_cnt),   0);
        chk("async reset mul_cnt",   32'(mul_cnt),   0);
        $display("async reset: cdb_valid=%0b add_cnt=%0d mul_cnt=%0d", cdb_valid, add_cnt, mul_cnt);
        @(posedge clock1);
        #3;
        rst_n = 1'b1;
        step();
        chk("release add_ready", 32'(add_ready), 1);
        chk("release mul_ready", 32'(mul_ready), 1);
        chk("release cdb_valid", 32'(cdb_valid), 0);
        drive(1, 1, 16'h0011, 1, 2, 16'h0022, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("post-reset tie src",  32'(cdb_src),  0);
        chk("post-reset tie tag",  32'(cdb_tag),  1);
        chk("post-reset tie data", 32'(cdb_data), 32'h0011);
        $display("post-reset tie: src=%0b tag=%0d data=%0h", cdb_src, cdb_tag, cdb_data);
        step();
        chk("post-reset second src",  32'(cdb_src),  1);
        chk("post-reset second tag",  32'(cdb_tag),  2);
        chk("post-reset second data", 32'(cdb_data), 32'h0022);
        $display("post-reset second: src=%0b tag=%0d data=%0h", cdb_src, cdb_tag, cdb_data);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
